// File: rtl/relm_div_pkg.sv
// Shared types and helpers for the ReLM sequential divider.
package relm_div_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIX,
    DONE
  } div_state_e;

  function automatic int unsigned calc_nit(input int unsigned wd, input int unsigned step);
    return (wd + step - 1) / step;
  endfunction

  // Divide-by-zero quotient is all ones; slice the low WD bits.
  localparam int unsigned                DBZ_MAXW = 128;
  localparam logic [DBZ_MAXW-1:0]        DBZ_QUOT = '1;

endpackage

// File: rtl/relm_div_step.sv
// One iteration of the divider: STEP chained restoring compare/subtract stages.
module relm_div_step
  import relm_div_pkg::*;
#(
  parameter int unsigned WD   = 32,
  parameter int unsigned STEP = 3
) (
  input  logic [WD-1:0]   rem_i,
  input  logic [STEP-1:0] bits_i,
  input  logic [WD-1:0]   dmag_i,
  output logic [WD-1:0]   rem_o,
  output logic [STEP-1:0] q_o
);

  logic [WD:0]   trial;
  logic [WD:0]   diff;
  logic [WD-1:0] r;

  // Partial remainder is always below |d|, so the shifted trial fits WD+1 bits
  // and the borrow bit of the WD+1-bit difference decides the quotient bit.
  always_comb begin
    r     = rem_i;
    q_o   = '0;
    trial = '0;
    diff  = '0;
    for (int unsigned k = 0; k < STEP; k++) begin
      trial              = {r, bits_i[STEP-1-k]};
      diff               = trial - {1'b0, dmag_i};
      q_o[STEP-1-k]      = ~diff[WD];
      r                  = diff[WD] ? trial[WD-1:0] : diff[WD-1:0];
    end
    rem_o = r;
  end

endmodule

// File: rtl/relm_div_seq.sv
// Multi-cycle signed/unsigned integer divider with valid/ready on both sides.
module relm_div_seq
  import relm_div_pkg::*;
#(
  parameter int unsigned WD   = 32,
  parameter int unsigned STEP = 3,
  parameter int unsigned NIT  = calc_nit(WD, STEP)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          signed_in,
  input  logic [WD-1:0] n_in,
  input  logic [WD-1:0] d_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WD-1:0] q_out,
  output logic [WD-1:0] r_out,
  output logic          dbz_out
);

  localparam int unsigned XW = NIT * STEP;
  localparam int unsigned CW = (NIT > 1) ? $clog2(NIT) : 1;

  div_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XW-1:0] nsh_q, nsh_d;
  logic [WD-1:0] rem_q, rem_d;
  logic [WD-1:0] quo_q, quo_d;
  logic [WD-1:0] dmag_q, dmag_d;
  logic [WD-1:0] n_q, n_d;
  logic [WD-1:0] d_q, d_d;
  logic          sgn_q, sgn_d;
  logic          sn_q, sn_d;
  logic          sd_q, sd_d;
  logic [WD-1:0] q_out_q, q_out_d;
  logic [WD-1:0] r_out_q, r_out_d;
  logic          dbz_q, dbz_d;

  logic          sn_w, sd_w;
  logic [WD-1:0] nmag_w;
  logic [WD-1:0] step_rem;
  logic [STEP-1:0] step_q;

  assign sn_w   = sgn_q & n_q[WD-1];
  assign sd_w   = sgn_q & d_q[WD-1];
  assign nmag_w = sn_w ? -n_q : n_q;

  relm_div_step #(
    .WD   (WD),
    .STEP (STEP)
  ) u_step (
    .rem_i  (rem_q),
    .bits_i (nsh_q[XW-1 -: STEP]),
    .dmag_i (dmag_q),
    .rem_o  (step_rem),
    .q_o    (step_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nsh_d   = nsh_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dmag_d  = dmag_q;
    n_d     = n_q;
    d_d     = d_q;
    sgn_d   = sgn_q;
    sn_d    = sn_q;
    sd_d    = sd_q;
    q_out_d = q_out_q;
    r_out_d = r_out_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          n_d     = n_in;
          d_d     = d_in;
          sgn_d   = signed_in;
          state_d = PREP;
        end
      end
      PREP: begin
        sn_d   = sn_w;
        sd_d   = sd_w;
        dmag_d = sd_w ? -d_q : d_q;
        nsh_d  = XW'(nmag_w);
        rem_d  = '0;
        quo_d  = '0;
        cnt_d  = CW'(NIT - 1);
        // Divide-by-zero skips the iterations but still passes through FIX,
        // which is where all result registers are loaded.
        state_d = (d_q == '0) ? FIX : ITER;
      end
      ITER: begin
        rem_d = step_rem;
        nsh_d = nsh_q << STEP;
        quo_d = {quo_q[WD-STEP-1:0], step_q};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        if (dmag_q == '0) begin
          q_out_d = DBZ_QUOT[WD-1:0];
          r_out_d = n_q;
          dbz_d   = 1'b1;
        end else begin
          q_out_d = (sn_q ^ sd_q) ? -quo_q : quo_q;
          r_out_d = sn_q ? -rem_q : rem_q;
          dbz_d   = 1'b0;
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      nsh_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dmag_q  <= '0;
      n_q     <= '0;
      d_q     <= '0;
      sgn_q   <= 1'b0;
      sn_q    <= 1'b0;
      sd_q    <= 1'b0;
      q_out_q <= '0;
      r_out_q <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nsh_q   <= nsh_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dmag_q  <= dmag_d;
      n_q     <= n_d;
      d_q     <= d_d;
      sgn_q   <= sgn_d;
      sn_q    <= sn_d;
      sd_q    <= sd_d;
      q_out_q <= q_out_d;
      r_out_q <= r_out_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign q_out     = q_out_q;
  assign r_out     = r_out_q;
  assign dbz_out   = dbz_q;

endmodule

// File: tb/tb_relm_div_seq.sv
// Directed and randomised checks of relm_div_seq at STEP=3 and STEP=4 side by side.
module tb_relm_div_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, signed_in, out_ready;
  logic [31:0] n_in, d_in;

  logic        in_ready3, out_valid3, dbz3;
  logic [31:0] q3, r3;
  logic        in_ready4, out_valid4, dbz4;
  logic [31:0] q4, r4;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  relm_div_seq #(.WD(32), .STEP(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3),
    .signed_in(signed_in), .n_in(n_in), .d_in(d_in), .out_valid(out_valid3),
    .out_ready(out_ready), .q_out(q3), .r_out(r3), .dbz_out(dbz3)
  );

  relm_div_seq #(.WD(32), .STEP(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .signed_in(signed_in), .n_in(n_in), .d_in(d_in), .out_valid(out_valid4),
    .out_ready(out_ready), .q_out(q4), .r_out(r4), .dbz_out(dbz4)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void ref_div(input logic sg, input logic [31:0] n, input logic [31:0] d,
                                  output logic [31:0] q, output logic [31:0] r);
    int a, b;
    a = n;
    b = d;
    if (sg && n == 32'h8000_0000 && d == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = '0;
    end else if (sg) begin
      q = a / b;
      r = a % b;
    end else begin
      q = n / d;
      r = n % d;
    end
  endfunction

  // Called #1 after a clock edge with both units idle.
  task automatic do_div(input string tag, input logic sg, input logic [31:0] n, input logic [31:0] d,
                        input logic [31:0] eq, input logic [31:0] er, input logic edbz,
                        input int unsigned hold);
    int unsigned lat3, lat4, cyc;
    lat3 = 0; lat4 = 0; cyc = 0;
    in_valid = 1'b1; signed_in = sg; n_in = n; d_in = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_busy3"}, in_ready3, 1'b0);
    chk({tag, "_busy4"}, in_ready4, 1'b0);
    while ((lat3 == 0 || lat4 == 0) && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (out_valid3 && lat3 == 0) lat3 = cyc;
      if (out_valid4 && lat4 == 0) lat4 = cyc;
    end
    chk({tag, "_lat3"}, lat3, edbz ? 2 : 13);
    chk({tag, "_lat4"}, lat4, edbz ? 2 : 10);
    chk({tag, "_q3"}, q3, eq);
    chk({tag, "_r3"}, r3, er);
    chk({tag, "_dbz3"}, dbz3, edbz);
    chk({tag, "_q4"}, q4, eq);
    chk({tag, "_r4"}, r4, er);
    chk({tag, "_dbz4"}, dbz4, edbz);
    repeat (hold) begin
      @(posedge clk); #1;
      chk({tag, "_hold_v"}, out_valid3, 1'b1);
      chk({tag, "_hold_q"}, q3, eq);
      chk({tag, "_hold_r"}, r3, er);
      chk({tag, "_hold_rdy"}, in_ready3, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_ov3_lo"}, out_valid3, 1'b0);
    chk({tag, "_ir3_hi"}, in_ready3, 1'b1);
    chk({tag, "_ov4_lo"}, out_valid4, 1'b0);
    chk({tag, "_ir4_hi"}, in_ready4, 1'b1);
  endtask

  initial begin
    logic [31:0] rn, rd, eq, er;
    logic        rs, seen;

    rst_n = 1'b0; in_valid = 1'b0; signed_in = 1'b0; out_ready = 1'b0;
    n_in = '0; d_in = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_ir", in_ready3, 1'b1);
    chk("rst_ov", out_valid3, 1'b0);
    chk("rst_q", q3, 32'h0);
    chk("rst_r", r3, 32'h0);
    chk("rst_dbz", dbz3, 1'b0);

    do_div("u100_7",   1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 5);
    do_div("s-7_2",    1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 0);
    do_div("s7_-2",    1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 0);
    do_div("uF9_2",    1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          1'b0, 0);
    do_div("smin_-1",  1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 0);
    do_div("umax_1",   1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 0);
    do_div("dbz",      1'b0, 32'd1234,       32'd0,          32'hFFFF_FFFF,  32'd1234,       1'b1, 3);
    do_div("sdbz",     1'b1, 32'hFFFF_FF9C,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FF9C,  1'b1, 0);
    do_div("s-100_7",  1'b1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0, 0);
    do_div("u5_9",     1'b0, 32'd5,          32'd9,          32'd0,          32'd5,          1'b0, 0);

    // Abort a divide part-way through the iterations.
    in_valid = 1'b1; signed_in = 1'b0; n_in = 32'd1000; d_in = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_ir", in_ready3, 1'b1);
    chk("abort_q", q3, 32'h0);
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid3 || out_valid4) seen = 1'b1;
    end
    chk("abort_noval", seen, 1'b0);
    chk("abort_ir4", in_ready4, 1'b1);

    for (int i = 0; i < 60; i++) begin
      rs = 1'($urandom_range(0, 1));
      rn = $urandom;
      rd = ($urandom_range(0, 2) == 0) ? $urandom : 32'($urandom_range(1, 300));
      if ($urandom_range(0, 3) == 0) rd = -rd;
      if (rd == '0) rd = 32'd1;
      ref_div(rs, rn, rd, eq, er);
      do_div($sformatf("rnd%0d", i), rs, rn, rd, eq, er, 1'b0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
